spi_lcd_rx: RTL and testbench



---
 rtl/spi_lcd_pkg.sv | 16 +
 rtl/spi_byte_rx.sv | 98 +++++++++
 rtl/spi_lcd_rx.sv | 193 +++++++++++++++++++
 tb/tb_spi_lcd_rx.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_lcd_pkg.sv
// Shared command codes and decoder state encoding for the SPI LCD responder.
package spi_lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        CA_P,
        RA_P,
        RAMWR,
        OTHER
    } lcd_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronizes the bus, detects sclk rises
// and assembles MSB-first bytes, tagging each with the dc level at its last bit.
module spi_byte_rx (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    input  logic       lcd_dc,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       dc_at_byte,
    output logic       cs_idle
);

    // bit order {dc, cs_n, mosi, sclk}; cs_n resets to its idle level
    localparam logic [3:0] SYNC_INIT = 4'b0100;

    logic [3:0] raw_bus;
    logic [3:0] sync_bus;

    assign raw_bus = {lcd_dc, spi_cs_n, spi_mosi, spi_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    meta_reg <= SYNC_INIT[gi];
                    sync_reg <= SYNC_INIT[gi];
                end else begin
                    meta_reg <= raw_bus[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bus[gi] = sync_reg;
        end
    endgenerate

    logic       sclk_prev_reg;
    logic       rise_reg;
    logic       bit_reg;
    logic       dc_reg;
    logic       cs_reg;
    logic [6:0] shift_reg;
    logic [2:0] cnt_reg;
    logic       byte_valid_reg;
    logic [7:0] byte_reg;
    logic       dc_byte_reg;

    // Edge detect is registered so the byte strobe lands a fixed pipeline depth after sclk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_prev_reg <= 1'b0;
            rise_reg      <= 1'b0;
            bit_reg       <= 1'b0;
            dc_reg        <= 1'b0;
            cs_reg        <= 1'b1;
        end else begin
            sclk_prev_reg <= sync_bus[0];
            rise_reg      <= sync_bus[0] & ~sclk_prev_reg & ~sync_bus[2];
            bit_reg       <= sync_bus[1];
            dc_reg        <= sync_bus[3];
            cs_reg        <= sync_bus[2];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_reg      <= 7'd0;
            cnt_reg        <= 3'd0;
            byte_valid_reg <= 1'b0;
            byte_reg       <= 8'd0;
            dc_byte_reg    <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (cs_reg) begin
                cnt_reg <= 3'd0;
            end else if (rise_reg) begin
                shift_reg <= {shift_reg[5:0], bit_reg};
                cnt_reg   <= cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    byte_valid_reg <= 1'b1;
                    byte_reg       <= {shift_reg, bit_reg};
                    dc_byte_reg    <= dc_reg;
                end
            end
        end
    end

    assign byte_valid = byte_valid_reg;
    assign rx_byte    = byte_reg;
    assign dc_at_byte = dc_byte_reg;
    assign cs_idle    = cs_reg;

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI LCD responder: decodes CASET/RASET/RAMWR from received bytes and emits
// addressed RGB565 pixel writes walking the programmed window.
module spi_lcd_rx
    import spi_lcd_pkg::*;
#(
    parameter int CW    = 9,
    parameter int X_MAX = 239,
    parameter int Y_MAX = 319
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          spi_sclk,
    input  logic          spi_mosi,
    input  logic          spi_cs_n,
    input  logic          lcd_dc,
    output logic          cmd_valid,
    output logic [7:0]    cmd_byte,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [15:0]   pix_data,
    output logic          frame_start
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       dc_at_byte;
    logic       cs_idle;

    spi_byte_rx u_byte_rx (
        .clk        (clk),
        .resetn     (resetn),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .lcd_dc     (lcd_dc),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .dc_at_byte (dc_at_byte),
        .cs_idle    (cs_idle)
    );

    lcd_state_t    state_reg, state_next;
    logic [1:0]    pcnt_reg, pcnt_next;
    logic          half_reg, half_next;
    logic [7:0]    hi_reg, hi_next;
    logic [23:0]   par_reg, par_next;
    logic [CW-1:0] xs_reg, xs_next, xe_reg, xe_next;
    logic [CW-1:0] ys_reg, ys_next, ye_reg, ye_next;
    logic [CW-1:0] x_reg, x_next, y_reg, y_next;
    logic          cmd_valid_reg, cmd_valid_next;
    logic [7:0]    cmd_byte_reg, cmd_byte_next;
    logic          pix_valid_reg, pix_valid_next;
    logic [CW-1:0] pix_x_reg, pix_x_next, pix_y_reg, pix_y_next;
    logic [15:0]   pix_data_reg, pix_data_next;
    logic          frame_start_reg, frame_start_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            pcnt_reg        <= 2'd0;
            half_reg        <= 1'b0;
            hi_reg          <= 8'd0;
            par_reg         <= 24'd0;
            xs_reg          <= '0;
            xe_reg          <= CW'(X_MAX);
            ys_reg          <= '0;
            ye_reg          <= CW'(Y_MAX);
            x_reg           <= '0;
            y_reg           <= '0;
            cmd_valid_reg   <= 1'b0;
            cmd_byte_reg    <= 8'h00;
            pix_valid_reg   <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            pix_data_reg    <= 16'd0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pcnt_reg        <= pcnt_next;
            half_reg        <= half_next;
            hi_reg          <= hi_next;
            par_reg         <= par_next;
            xs_reg          <= xs_next;
            xe_reg          <= xe_next;
            ys_reg          <= ys_next;
            ye_reg          <= ye_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            cmd_valid_reg   <= cmd_valid_next;
            cmd_byte_reg    <= cmd_byte_next;
            pix_valid_reg   <= pix_valid_next;
            pix_x_reg       <= pix_x_next;
            pix_y_reg       <= pix_y_next;
            pix_data_reg    <= pix_data_next;
            frame_start_reg <= frame_start_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pcnt_next        = pcnt_reg;
        half_next        = half_reg;
        hi_next          = hi_reg;
        par_next         = par_reg;
        xs_next          = xs_reg;
        xe_next          = xe_reg;
        ys_next          = ys_reg;
        ye_next          = ye_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        cmd_valid_next   = 1'b0;
        cmd_byte_next    = cmd_byte_reg;
        pix_valid_next   = 1'b0;
        pix_x_next       = pix_x_reg;
        pix_y_next       = pix_y_reg;
        pix_data_next    = pix_data_reg;
        frame_start_next = 1'b0;

        // A deselect drops any half-received pixel but keeps the stream position.
        if (cs_idle) begin
            half_next = 1'b0;
        end

        if (byte_valid) begin
            if (!dc_at_byte) begin
                cmd_valid_next = 1'b1;
                cmd_byte_next  = rx_byte;
                pcnt_next      = 2'd0;
                half_next      = 1'b0;
                case (rx_byte)
                    CMD_CASET: state_next = CA_P;
                    CMD_RASET: state_next = RA_P;
                    CMD_RAMWR: begin
                        state_next       = RAMWR;
                        frame_start_next = 1'b1;
                        x_next           = xs_reg;
                        y_next           = ys_reg;
                    end
                    default:   state_next = OTHER;
                endcase
            end else begin
                case (state_reg)
                    CA_P, RA_P: begin
                        if (pcnt_reg == 2'd3) begin
                            if (state_reg == CA_P) begin
                                xs_next = CW'(par_reg[23:8]);
                                xe_next = CW'({par_reg[7:0], rx_byte});
                            end else begin
                                ys_next = CW'(par_reg[23:8]);
                                ye_next = CW'({par_reg[7:0], rx_byte});
                            end
                            pcnt_next  = 2'd0;
                            state_next = IDLE;
                        end else begin
                            par_next  = {par_reg[15:0], rx_byte};
                            pcnt_next = pcnt_reg + 2'd1;
                        end
                    end
                    RAMWR: begin
                        if (!half_reg) begin
                            hi_next   = rx_byte;
                            half_next = 1'b1;
                        end else begin
                            half_next      = 1'b0;
                            pix_valid_next = 1'b1;
                            pix_data_next  = {hi_reg, rx_byte};
                            pix_x_next     = x_reg;
                            pix_y_next     = y_reg;
                            // wrap tests equality only, so inverted windows run modulo 2^CW
                            if (x_reg == xe_reg) begin
                                x_next = xs_reg;
                                y_next = (y_reg == ye_reg) ? ys_reg : y_reg + 1'b1;
                            end else begin
                                x_next = x_reg + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_valid   = cmd_valid_reg;
    assign cmd_byte    = cmd_byte_reg;
    assign pix_valid   = pix_valid_reg;
    assign pix_x       = pix_x_reg;
    assign pix_y       = pix_y_reg;
    assign pix_data    = pix_data_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Bench for spi_lcd_rx: drives SPI byte streams and compares strobes against a
// byte-level model of the LCD command set.
module tb_spi_lcd_rx;

    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          resetn;
    logic          spi_sclk, spi_mosi, spi_cs_n, lcd_dc;
    logic          cmd_valid, pix_valid, frame_start;
    logic [7:0]    cmd_byte;
    logic [CW-1:0] pix_x, pix_y;
    logic [15:0]   pix_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_lcd_rx #(.CW(CW), .X_MAX(239), .Y_MAX(319)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .lcd_dc      (lcd_dc),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .frame_start (frame_start)
    );

    // observed strobes
    logic [7:0]  obs_cmd[$];
    logic [33:0] obs_pix[$];
    int          obs_frames;

    always @(negedge clk) begin
        if (cmd_valid)   obs_cmd.push_back(cmd_byte);
        if (pix_valid)   obs_pix.push_back({pix_x, pix_y, pix_data});
        if (frame_start) obs_frames++;
    end

    // reference model: window state plus a stream position, driven per byte
    logic [7:0]  exp_cmd[$];
    logic [33:0] exp_pix[$];
    int          exp_frames;
    int          m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_hi, m_mode;
    int          m_par[$];

    task automatic model_reset();
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
        m_x = 0; m_y = 0; m_hi = -1; m_mode = 0;
        m_par.delete();
    endtask

    task automatic model_byte(input logic dc, input logic [7:0] b);
        int s, e;
        if (!dc) begin
            exp_cmd.push_back(b);
            m_par.delete();
            m_hi = -1;
            m_mode = (b == 8'h2A) ? 1 : (b == 8'h2B) ? 2 : (b == 8'h2C) ? 3 : 0;
            if (m_mode == 3) begin
                exp_frames++;
                m_x = m_xs;
                m_y = m_ys;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_par.push_back(int'(b));
            if (m_par.size() == 4) begin
                s = (m_par[0] * 256 + m_par[1]) % 512;
                e = (m_par[2] * 256 + m_par[3]) % 512;
                if (m_mode == 1) begin m_xs = s; m_xe = e; end
                else             begin m_ys = s; m_ye = e; end
                m_mode = 0;
                m_par.delete();
            end
        end else if (m_mode == 3) begin
            if (m_hi < 0) begin
                m_hi = int'(b);
            end else begin
                exp_pix.push_back({9'(m_x), 9'(m_y), 8'(m_hi), b});
                m_hi = -1;
                if (m_x == m_xe) begin
                    m_x = m_xs;
                    m_y = (m_y == m_ye) ? m_ys : (m_y + 1) % 512;
                end else begin
                    m_x = (m_x + 1) % 512;
                end
            end
        end
    endtask

    task automatic clear_queues();
        obs_cmd.delete(); obs_pix.delete(); obs_frames = 0;
        exp_cmd.delete(); exp_pix.delete(); exp_frames = 0;
    endtask

    // SPI master, sclk = clk/4, edges kept 3 ns after a clk rising edge
    task automatic spi_bits(input logic dc, input logic [7:0] v, input int nbits);
        lcd_dc = dc;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = v[i];
            #20 spi_sclk = 1'b1;
            #20 spi_sclk = 1'b0;
        end
        if (nbits == 8) model_byte(dc, v);
    endtask

    task automatic send(input logic dc, input logic [7:0] v);
        spi_bits(dc, v, 8);
    endtask

    task automatic cs_begin();
        @(posedge clk);
        #3 spi_cs_n = 1'b0;
        #40;
    endtask

    task automatic cs_end();
        #40 spi_cs_n = 1'b1;
        if (m_mode == 3) m_hi = -1;
        #120;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; lcd_dc = 1'b0;
        resetn = 1'b0;
        model_reset();
        #1;
        total++;
        if ({cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_start} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_start});
        end
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (3) @(posedge clk);
        total++;
        if ({cmd_valid, pix_valid, frame_start} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle_strobes got=%b want=000", {cmd_valid, pix_valid, frame_start});
        end
    endtask

    task automatic test_cmd();
        clear_queues();
        cs_begin();
        send(1'b0, 8'h01);
        cs_end();
        total++;
        if (obs_cmd.size() != 1 || obs_cmd[0] !== 8'h01) begin
            bad++;
            $display("FAIL cmd_single got_n=%0d got=%h want_n=1 want=01", obs_cmd.size(),
                     obs_cmd.size() > 0 ? obs_cmd[0] : 8'hxx);
        end
        total++;
        if (obs_pix.size() != 0 || obs_frames != 0) begin
            bad++;
            $display("FAIL cmd_no_pix got_pix=%0d got_frames=%0d want=0/0", obs_pix.size(), obs_frames);
        end
    endtask

    task automatic test_window();
        logic [33:0] want[5];
        logic [15:0] px[5];
        want[0] = {9'd10, 9'd20, 16'hF800};
        want[1] = {9'd11, 9'd20, 16'h07E0};
        want[2] = {9'd10, 9'd21, 16'h001F};
        want[3] = {9'd11, 9'd21, 16'hFFFF};
        want[4] = {9'd10, 9'd20, 16'h1234};
        px[0] = 16'hF800; px[1] = 16'h07E0; px[2] = 16'h001F; px[3] = 16'hFFFF; px[4] = 16'h1234;
        clear_queues();
        cs_begin();
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h0B);
        send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h14); send(1'b1, 8'h00); send(1'b1, 8'h15);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, px[i][15:8]);
            send(1'b1, px[i][7:0]);
        end
        cs_end();
        total++;
        if (obs_frames != 1) begin
            bad++;
            $display("FAIL win_frame_start got=%0d want=1", obs_frames);
        end
        total++;
        if (obs_pix.size() != 5) begin
            bad++;
            $display("FAIL win_pix_count got=%0d want=5", obs_pix.size());
        end
        for (int i = 0; i < 5 && i < obs_pix.size(); i++) begin
            total++;
            if (obs_pix[i] !== want[i]) begin
                bad++;
                $display("FAIL win_pix%0d got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h", i,
                         obs_pix[i][33:25], obs_pix[i][24:16], obs_pix[i][15:0],
                         want[i][33:25], want[i][24:16], want[i][15:0]);
            end
        end
    endtask

    task automatic test_short_caset();
        do_reset();
        clear_queues();
        cs_begin();
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h33);
        send(1'b0, 8'h2C); send(1'b1, 8'h5A); send(1'b1, 8'hC3);
        cs_end();
        total++;
        if (obs_pix.size() != 1 || obs_pix[0] !== {9'd0, 9'd0, 16'h5AC3}) begin
            bad++;
            $display("FAIL short_caset got_n=%0d got=%h want_n=1 want=%h", obs_pix.size(),
                     obs_pix.size() > 0 ? obs_pix[0] : 34'hx, {9'd0, 9'd0, 16'h5AC3});
        end
    endtask

    task automatic test_split_pixel();
        do_reset();
        clear_queues();
        cs_begin();
        send(1'b0, 8'h2C); send(1'b1, 8'h77);
        cs_end();
        cs_begin();
        send(1'b1, 8'hAB); send(1'b1, 8'hCD);
        cs_end();
        total++;
        if (obs_pix.size() != 1 || obs_pix[0] !== {9'd0, 9'd0, 16'hABCD}) begin
            bad++;
            $display("FAIL split_pixel got_n=%0d got=%h want_n=1 want=%h", obs_pix.size(),
                     obs_pix.size() > 0 ? obs_pix[0] : 34'hx, {9'd0, 9'd0, 16'hABCD});
        end
    endtask

    task automatic test_partial_byte();
        clear_queues();
        cs_begin();
        spi_bits(1'b0, 8'hFF, 5);
        cs_end();
        total++;
        if (obs_cmd.size() != 0) begin
            bad++;
            $display("FAIL partial_no_strobe got=%0d want=0", obs_cmd.size());
        end
        cs_begin();
        send(1'b0, 8'h96);
        cs_end();
        total++;
        if (obs_cmd.size() != 1 || obs_cmd[0] !== 8'h96) begin
            bad++;
            $display("FAIL partial_next_byte got_n=%0d got=%h want_n=1 want=96", obs_cmd.size(),
                     obs_cmd.size() > 0 ? obs_cmd[0] : 8'hxx);
        end
    endtask

    task automatic test_async_reset();
        clear_queues();
        cs_begin();
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h05);
        send(1'b0, 8'h2C); send(1'b1, 8'h12); send(1'b1, 8'h34);
        spi_bits(1'b1, 8'hFF, 4);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_start} !== '0) begin
            bad++;
            $display("FAIL async_reset_outputs got=%h want=0",
                     {cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_start});
        end
        spi_cs_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (3) @(posedge clk);
        clear_queues();
        cs_begin();
        send(1'b0, 8'h2C);
        send(1'b1, 8'h01); send(1'b1, 8'h02);
        send(1'b1, 8'h03); send(1'b1, 8'h04);
        cs_end();
        total++;
        if (obs_pix.size() != 2) begin
            bad++;
            $display("FAIL async_post_count got=%0d want=2", obs_pix.size());
        end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            total++;
            if (obs_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL async_post_pix%0d got=%h want=%h", i, obs_pix[i], exp_pix[i]);
            end
        end
    endtask

    task automatic test_latency();
        int lat;
        clear_queues();
        lat = 0;
        cs_begin();
        fork
            send(1'b0, 8'h3C);
            begin
                repeat (8) @(posedge spi_sclk);
                @(posedge clk);
                for (int k = 1; k <= 8 && lat == 0; k++) begin
                    @(posedge clk);
                    #1;
                    if (cmd_valid) lat = k;
                end
            end
        join
        cs_end();
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL latency got=%0d want=4", lat);
        end
    endtask

    task automatic test_random_stream();
        logic [15:0] s16, e16, d16;
        int npix;
        for (int it = 0; it < 4; it++) begin
            clear_queues();
            cs_begin();
            for (int axis = 0; axis < 2; axis++) begin
                s16 = 16'($urandom_range(0, 40)) | (($urandom_range(0, 1) == 1) ? 16'hFE00 : 16'h0000);
                if ($urandom_range(0, 3) == 0)
                    e16 = 16'(s16[8:0]) - 16'd1;
                else
                    e16 = 16'(s16[8:0]) + 16'($urandom_range(0, 3));
                send(1'b0, axis == 0 ? 8'h2A : 8'h2B);
                send(1'b1, s16[15:8]); send(1'b1, s16[7:0]);
                send(1'b1, e16[15:8]); send(1'b1, e16[7:0]);
            end
            send(1'b0, 8'h04);
            send(1'b1, 8'($urandom));
            send(1'b0, 8'h2C);
            npix = $urandom_range(3, 10);
            for (int p = 0; p < npix; p++) begin
                d16 = 16'($urandom);
                send(1'b1, d16[15:8]);
                send(1'b1, d16[7:0]);
                if ($urandom_range(0, 3) == 0) begin
                    cs_end();
                    cs_begin();
                end
            end
            cs_end();
            total++;
            if (obs_cmd.size() != exp_cmd.size() || obs_frames != exp_frames) begin
                bad++;
                $display("FAIL rand%0d_cmds got_n=%0d got_fr=%0d want_n=%0d want_fr=%0d", it,
                         obs_cmd.size(), obs_frames, exp_cmd.size(), exp_frames);
            end
            total++;
            if (obs_pix.size() != exp_pix.size()) begin
                bad++;
                $display("FAIL rand%0d_pix_count got=%0d want=%0d", it, obs_pix.size(), exp_pix.size());
            end
            for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
                total++;
                if (obs_pix[i] !== exp_pix[i]) begin
                    bad++;
                    $display("FAIL rand%0d_pix%0d got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h", it, i,
                             obs_pix[i][33:25], obs_pix[i][24:16], obs_pix[i][15:0],
                             exp_pix[i][33:25], exp_pix[i][24:16], exp_pix[i][15:0]);
                end
            end
        end
    endtask

    initial begin
        obs_frames = 0;
        exp_frames = 0;
        test_reset();
        test_cmd();
        test_window();
        test_short_caset();
        test_split_pixel();
        test_partial_byte();
        test_async_reset();
        test_latency();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
